axi4lite_reg_responder: RTL and testbench

- AXI4-Lite slave (responder) serving the register transactions issued by the S00_AXI master BFM and by the system-side interconnect.
- Holds four 32-bit control registers for the 65816 interface, with byte-strobe writes and OKAY responses.
- Exports the register contents and a per-register write-commit pulse to the 65816-side logic.
- At most one write and one read outstanding; read and write paths are independent.

---
 rtl/axi4lite_reg_responder.sv | 133 +++++++++++++
 tb/tb_axi4lite_reg_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_responder.sv
// AXI4-Lite responder exposing four 32-bit control registers to the 65816-side logic,
// with byte-strobe writes, per-register commit pulses and independent read/write paths.
module axi4lite_reg_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic [3:0]                        wr_pulse
);

    logic        en;
    logic        aw_held;
    logic        w_held;
    logic        bvalid;
    logic        rvalid;
    logic [1:0]  aw_idx;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [31:0] rdata;
    logic [3:0]  pulse;
    logic [31:0] regs [4];

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic unused_inputs;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = en & ~aw_held & ~bvalid;
    assign S_AXI_WREADY  = en & ~w_held & ~bvalid;
    assign S_AXI_ARREADY = en & ~rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign wr_pulse      = pulse;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = aw_held & w_held & ~bvalid;

    // Ready lines stay low through reset and rise one edge after release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) en <= 1'b0;
        else                en <= 1'b1;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            pulse   <= '0;
        end else begin
            pulse <= '0;
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                bvalid        <= 1'b1;
                pulse[aw_idx] <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_idx  <= S_AXI_AWADDR[3:2];
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                    w_data <= S_AXI_WDATA;
                    w_strb <= S_AXI_WSTRB;
                end
                if (bvalid & S_AXI_BREADY) bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int unsigned r = 0; r < 4; r++) regs[r] <= '0;
        end else if (commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    // Read samples the pre-commit register value when a commit lands on the same edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= regs[S_AXI_ARADDR[3:2]];
        end else if (rvalid & S_AXI_RREADY) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned r = 0; r < 4; r++) reg_out[32*r +: 32] = regs[r];
    end

endmodule

// File: tb/tb_axi4lite_reg_responder.sv
// Self-checking bench for axi4lite_reg_responder: directed scenarios plus randomized
// write/read traffic compared against a byte-lane register model.
module tb_axi4lite_reg_responder;

    logic         tb_ACLK = 1'b0;
    logic         rst_n;
    logic [3:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [3:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic [31:0] model_regs [4];

    always #5 tb_ACLK = ~tb_ACLK;

    always @(posedge tb_ACLK) if (wr_pulse !== 4'h0) pulse_cnt++;

    axi4lite_reg_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [127:0] model_flat();
        return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
    endfunction

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int bready_delay,
                             output int lat, output logic [1:0] resp, output logic [3:0] pulse,
                             output int npulse, output bit rdy_bad, output bit b_clr_bad,
                             output bit timeout);
        int cyc, hs_aw, hs_w, last, p0;
        cyc = 0; hs_aw = -1; hs_w = -1; lat = -1; resp = 2'bxx; pulse = 4'hx; npulse = -1;
        rdy_bad = 0; b_clr_bad = 0; timeout = 0;
        @(negedge tb_ACLK);
        p0 = pulse_cnt;
        awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom);
        wvalid = 1'b1; awvalid = (w_lead == 0);
        while ((hs_aw < 0 || hs_w < 0) && cyc < 100) begin
            if (awvalid && awready) hs_aw = cyc;
            if (wvalid && wready) hs_w = cyc;
            @(negedge tb_ACLK); cyc++;
            if (hs_aw >= 0) awvalid = 1'b0;
            if (hs_w >= 0) wvalid = 1'b0;
            if (hs_aw < 0 && cyc >= w_lead) awvalid = 1'b1;
        end
        if (hs_aw < 0 || hs_w < 0) begin
            awvalid = 1'b0; wvalid = 1'b0; timeout = 1; return;
        end
        last = (hs_aw > hs_w) ? hs_aw : hs_w;
        while (!bvalid && cyc < last + 100) begin @(negedge tb_ACLK); cyc++; end
        if (!bvalid) begin timeout = 1; return; end
        lat = cyc - last; resp = bresp; pulse = wr_pulse;
        for (int i = 0; i < bready_delay; i++) begin
            if (awready || wready) rdy_bad = 1;
            @(negedge tb_ACLK);
            if (!bvalid) b_clr_bad = 1;
        end
        if (awready || wready) rdy_bad = 1;
        bready = 1'b1;
        @(negedge tb_ACLK);
        bready = 1'b0;
        if (bvalid || !awready || !wready) b_clr_bad = 1;
        npulse = pulse_cnt - p0;
    endtask

    task automatic axi_read(input logic [3:0] addr, input int rready_delay,
                            output logic [31:0] data, output logic [1:0] resp, output int lat,
                            output bit hold_bad, output bit timeout);
        int cyc, hs;
        cyc = 0; hs = -1; lat = -1; data = 'x; resp = 2'bxx; hold_bad = 0; timeout = 0;
        @(negedge tb_ACLK);
        araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
        while (hs < 0 && cyc < 100) begin
            if (arready) hs = cyc;
            @(negedge tb_ACLK); cyc++;
            if (hs >= 0) arvalid = 1'b0;
        end
        if (hs < 0) begin arvalid = 1'b0; timeout = 1; return; end
        while (!rvalid && cyc < hs + 100) begin @(negedge tb_ACLK); cyc++; end
        if (!rvalid) begin timeout = 1; return; end
        lat = cyc - hs; data = rdata; resp = rresp;
        for (int i = 0; i < rready_delay; i++) begin
            if (arready) hold_bad = 1;
            @(negedge tb_ACLK);
            if (!rvalid || rdata !== data) hold_bad = 1;
        end
        if (arready) hold_bad = 1;
        rready = 1'b1;
        @(negedge tb_ACLK);
        rready = 1'b0;
        if (rvalid || !arready) hold_bad = 1;
    endtask

    task automatic test_reset();
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b expected 000", {awready, wready, arready});
        end
        checks++;
        if ({bvalid, rvalid, bresp, rresp, wr_pulse} !== 10'h0 || rdata !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: got b%b r%b rdata %h pulse %h expected all zero",
                               bvalid, rvalid, rdata, wr_pulse);
        end
        checks++;
        if (reg_out !== 128'h0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", reg_out);
        end
        @(negedge tb_ACLK);
        rst_n = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b0) begin
            errors++; $display("FAIL release_ready_early: got %b expected 0", awready);
        end
        @(negedge tb_ACLK);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL release_ready: got %b expected 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        logic [31:0] vals [4];
        logic [31:0] d; logic [1:0] resp; logic [3:0] pulse;
        int lat, np; bit rb, bc, to, hb;
        vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001; vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(4*i), vals[i], 4'hF, 0, 0, lat, resp, pulse, np, rb, bc, to);
            model_regs[i] = merge(model_regs[i], vals[i], 4'hF);
            checks++;
            if (to || resp !== 2'b00 || lat != 2 || pulse !== 4'(1 << i) || np != 1 || rb || bc) begin
                errors++; $display("FAIL basic_write%0d: got to%0d resp%b lat%0d pulse%h n%0d rb%0d bc%0d expected resp00 lat2 pulse%h n1",
                                   i, to, resp, lat, pulse, np, rb, bc, 4'(1 << i));
            end
            axi_read(4'(4*i), 0, d, resp, lat, hb, to);
            checks++;
            if (to || d !== model_regs[i] || resp !== 2'b00 || lat != 1 || hb) begin
                errors++; $display("FAIL basic_read%0d: got %h resp%b lat%0d hb%0d expected %h resp00 lat1",
                                   i, d, resp, lat, hb, model_regs[i]);
            end
        end
        checks++;
        if (reg_out !== 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF) begin
            errors++; $display("FAIL basic_reg_out: got %h expected BEEF0011DEAD0011ABCD00010101FFFF", reg_out);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] resp; logic [3:0] pulse;
        int lat, np; bit rb, bc, to, hb;
        axi_write(4'h4, 32'h11223344, 4'h5, 0, 0, lat, resp, pulse, np, rb, bc, to);
        model_regs[1] = merge(model_regs[1], 32'h11223344, 4'h5);
        axi_read(4'h4, 0, d, resp, lat, hb, to);
        checks++;
        if (to || d !== 32'hAB220044 || d !== model_regs[1]) begin
            errors++; $display("FAIL strobe_read: got %h expected AB220044", d);
        end
        axi_write(4'h7, 32'h99999999, 4'h0, 0, 0, lat, resp, pulse, np, rb, bc, to);
        checks++;
        if (to || resp !== 2'b00 || pulse !== 4'h2 || np != 1 || reg_out !== model_flat()) begin
            errors++; $display("FAIL strobe_zero: got resp%b pulse%h n%0d regs %h expected pulse2 n1 regs %h",
                               resp, pulse, np, reg_out, model_flat());
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] v; logic [1:0] resp; logic [3:0] pulse;
        int lat, np; bit rb, bc, to;
        for (int lead = 3; lead >= 0; lead -= 3) begin
            v = $urandom;
            axi_write(4'hC, v, 4'hF, lead, 5, lat, resp, pulse, np, rb, bc, to);
            model_regs[3] = v;
            checks++;
            if (to || lat != 2 || rb || bc || np != 1 || pulse !== 4'h8) begin
                errors++; $display("FAIL order_lead%0d: got to%0d lat%0d rb%0d bc%0d n%0d pulse%h expected lat2 n1 pulse8",
                                   lead, to, lat, rb, bc, np, pulse);
            end
            checks++;
            if (reg_out !== model_flat()) begin
                errors++; $display("FAIL order_regs%0d: got %h expected %h", lead, reg_out, model_flat());
            end
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] d; logic [1:0] resp; int lat; bit hb, to;
        axi_read(4'h8, 4, d, resp, lat, hb, to);
        checks++;
        if (to || d !== model_regs[2] || lat != 1 || hb) begin
            errors++; $display("FAIL read_stall: got %h lat%0d hb%0d expected %h lat1 stable", d, lat, hb, model_regs[2]);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d, old_v; logic [1:0] resp; logic [3:0] pulse;
        int lat, np; bit rb, bc, to, hb;
        axi_write(4'h8, 32'hDEAD0011, 4'hF, 0, 0, lat, resp, pulse, np, rb, bc, to);
        model_regs[2] = 32'hDEAD0011;
        old_v = model_regs[2];
        @(negedge tb_ACLK);
        awaddr = 4'h8; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        checks++;
        if ({awready, wready} !== 2'b11) begin
            errors++; $display("FAIL coll_wready: got %b expected 11", {awready, wready});
        end
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0; araddr = 4'h8; arvalid = 1'b1;
        checks++;
        if (arready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("FAIL coll_arready: got ar%b b%b expected ar1 b0", arready, bvalid);
        end
        @(negedge tb_ACLK);
        arvalid = 1'b0;
        model_regs[2] = 32'h0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1 || wr_pulse !== 4'h4) begin
            errors++; $display("FAIL coll_same_cycle: got rv%b rdata %h bv%b pulse %h expected rv1 %h bv1 pulse4",
                               rvalid, rdata, bvalid, wr_pulse, old_v);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge tb_ACLK);
        bready = 1'b0; rready = 1'b0;
        axi_read(4'h8, 0, d, resp, lat, hb, to);
        checks++;
        if (to || d !== model_regs[2]) begin
            errors++; $display("FAIL coll_after: got %h expected %h", d, model_regs[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [3:0] pulse;
        int lat, np, p0; bit rb, bc, to, bad;
        @(negedge tb_ACLK);
        awaddr = 4'h0; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        p0 = pulse_cnt;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_ready: got %b expected 000", {awready, wready, arready});
        end
        @(negedge tb_ACLK);
        wvalid = 1'b0;
        @(negedge tb_ACLK);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) model_regs[r] = 32'h0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_ACLK);
            if (bvalid || wr_pulse !== 4'h0) bad = 1;
        end
        checks++;
        if (bad || pulse_cnt != p0 || reg_out !== 128'h0) begin
            errors++; $display("FAIL mid_reset_discard: got bad%0d pulses%0d regs %h expected none and 0",
                               bad, pulse_cnt - p0, reg_out);
        end
        axi_write(4'h0, 32'h5, 4'hF, 0, 0, lat, resp, pulse, np, rb, bc, to);
        model_regs[0] = 32'h5;
        checks++;
        if (to || lat != 2 || pulse !== 4'h1 || np != 1 || reg_out !== model_flat()) begin
            errors++; $display("FAIL mid_reset_rewrite: got lat%0d pulse%h n%0d regs %h expected lat2 pulse1 n1 %h",
                               lat, pulse, np, reg_out, model_flat());
        end
    endtask

    task automatic test_random();
        logic [31:0] v, d; logic [3:0] a, s; logic [1:0] resp; logic [3:0] pulse;
        int lat, np; bit rb, bc, to, hb;
        for (int it = 0; it < 40; it++) begin
            a = 4'($urandom); v = $urandom; s = 4'($urandom);
            axi_write(a, v, s, $urandom_range(0, 2), $urandom_range(0, 2), lat, resp, pulse, np, rb, bc, to);
            model_regs[a / 4] = merge(model_regs[a / 4], v, s);
            checks++;
            if (to || resp !== 2'b00 || lat != 2 || pulse !== 4'(1 << (a / 4)) || np != 1 || rb || bc) begin
                errors++; $display("FAIL rand_write%0d: got to%0d resp%b lat%0d pulse%h n%0d expected lat2 pulse%h n1",
                                   it, to, resp, lat, pulse, np, 4'(1 << (a / 4)));
            end
            a = 4'($urandom);
            axi_read(a, $urandom_range(0, 2), d, resp, lat, hb, to);
            checks++;
            if (to || d !== model_regs[a / 4] || resp !== 2'b00 || lat != 1 || hb) begin
                errors++; $display("FAIL rand_read%0d: got %h resp%b lat%0d hb%0d expected %h",
                                   it, d, resp, lat, hb, model_regs[a / 4]);
            end
        end
        checks++;
        if (reg_out !== model_flat()) begin
            errors++; $display("FAIL rand_reg_out: got %h expected %h", reg_out, model_flat());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int r = 0; r < 4; r++) model_regs[r] = 32'h0;
        repeat (3) @(negedge tb_ACLK);
        test_reset();
        test_basic();
        test_strobe();
        test_w_before_aw();
        test_read_stall();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
